// File: rtl/tx_pll_sequencer.sv
// TX PLL reset/lock sequencer in the reference-clock domain.
// Holds the PLL in reset, qualifies LOCK, retries on failure, then falls back to bypass.
module tx_pll_sequencer #(
   parameter int unsigned RESET_CYCLES = 20,
   parameter int unsigned LOCK_TIMEOUT = 20000,
   parameter int unsigned LOCK_STABLE  = 256,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       pll_lock_i,
   input  logic       force_bypass_i,
   input  logic       restart_i,
   output logic       pll_resetb_o,
   output logic       pll_bypass_o,
   output logic       pll_ready_o,
   output logic       pll_fault_o,
   output logic [3:0] retry_count_o,
   output logic [7:0] loss_count_o,
   output logic [2:0] state_o
);

   localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
   localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned STB_W  = $clog2(LOCK_STABLE + 1);

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_FILTER = 3'd2,
      ST_LOCKED = 3'd3,
      ST_FAULT  = 3'd4,
      ST_BYPASS = 3'd5
   } state_e;

   state_e            state_q;
   logic              lock_meta_q;
   logic              lock_s_q;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [TMO_W-1:0]  timer_q;
   logic [STB_W-1:0]  stable_q;
   logic              resetb_q;
   logic              bypass_q;
   logic              ready_q;
   logic              fault_q;
   logic [3:0]        retry_q;
   logic [7:0]        loss_q;

   logic [TMO_W-1:0]  timer_d;
   logic [STB_W-1:0]  stable_d;
   logic [3:0]        retry_d;
   logic [7:0]        loss_d;
   logic              hold_done_c;
   logic              tmo_hit_c;
   logic              stable_done_c;
   logic              retry_fault_c;

   // Saturating increments and terminal-count decodes
   always_comb begin
      timer_d       = (timer_q >= TMO_W'(LOCK_TIMEOUT)) ? timer_q : timer_q + TMO_W'(1);
      stable_d      = (stable_q >= STB_W'(LOCK_STABLE)) ? stable_q : stable_q + STB_W'(1);
      retry_d       = (retry_q >= 4'(MAX_RETRIES)) ? retry_q : retry_q + 4'd1;
      loss_d        = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
      hold_done_c   = (hold_cnt_q >= HOLD_W'(RESET_CYCLES - 1));
      tmo_hit_c     = (timer_q >= TMO_W'(LOCK_TIMEOUT - 1));
      stable_done_c = (stable_d >= STB_W'(LOCK_STABLE));
      retry_fault_c = (retry_d >= 4'(MAX_RETRIES));
   end

   // Synchronizer, sequencing FSM and registered outputs
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_HOLD;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         hold_cnt_q  <= '0;
         timer_q     <= '0;
         stable_q    <= '0;
         resetb_q    <= 1'b0;
         bypass_q    <= 1'b0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         retry_q     <= '0;
         loss_q      <= '0;
      end else begin
         lock_meta_q <= pll_lock_i;
         lock_s_q    <= lock_meta_q;

         if (force_bypass_i) begin
            state_q    <= ST_BYPASS;
            hold_cnt_q <= '0;
            timer_q    <= '0;
            stable_q   <= '0;
            resetb_q   <= 1'b0;
            bypass_q   <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
         end else if (restart_i && (state_q != ST_BYPASS)) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            timer_q    <= '0;
            stable_q   <= '0;
            resetb_q   <= 1'b0;
            bypass_q   <= 1'b0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            retry_q    <= '0;
         end else begin
            case (state_q)
               ST_HOLD: begin
                  if (hold_done_c) begin
                     state_q    <= ST_WAIT;
                     hold_cnt_q <= '0;
                     timer_q    <= '0;
                     resetb_q   <= 1'b1;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                  end
               end

               ST_WAIT, ST_FILTER: begin
                  if (tmo_hit_c) begin
                     retry_q    <= retry_d;
                     hold_cnt_q <= '0;
                     timer_q    <= '0;
                     stable_q   <= '0;
                     resetb_q   <= 1'b0;
                     if (retry_fault_c) begin
                        state_q  <= ST_FAULT;
                        bypass_q <= 1'b1;
                        fault_q  <= 1'b1;
                     end else begin
                        state_q  <= ST_HOLD;
                     end
                  end else if (lock_s_q) begin
                     timer_q <= timer_d;
                     // First qualifying sample from WAIT counts as one
                     if (state_q == ST_WAIT) begin
                        stable_q <= STB_W'(1);
                        if (LOCK_STABLE <= 1) begin
                           state_q <= ST_LOCKED;
                           ready_q <= 1'b1;
                        end else begin
                           state_q <= ST_FILTER;
                        end
                     end else begin
                        stable_q <= stable_d;
                        if (stable_done_c) begin
                           state_q <= ST_LOCKED;
                           ready_q <= 1'b1;
                        end
                     end
                  end else begin
                     state_q  <= ST_WAIT;
                     timer_q  <= timer_d;
                     stable_q <= '0;
                  end
               end

               ST_LOCKED: begin
                  if (!lock_s_q) begin
                     state_q    <= ST_HOLD;
                     loss_q     <= loss_d;
                     hold_cnt_q <= '0;
                     timer_q    <= '0;
                     stable_q   <= '0;
                     resetb_q   <= 1'b0;
                     ready_q    <= 1'b0;
                  end
               end

               ST_FAULT: begin
                  state_q <= ST_FAULT;
               end

               ST_BYPASS: begin
                  // FORCE_BYPASS has dropped: start a fresh sequence
                  state_q    <= ST_HOLD;
                  retry_q    <= '0;
                  hold_cnt_q <= '0;
                  timer_q    <= '0;
                  stable_q   <= '0;
                  resetb_q   <= 1'b0;
                  bypass_q   <= 1'b0;
                  ready_q    <= 1'b0;
                  fault_q    <= 1'b0;
               end

               default: begin
                  state_q    <= ST_HOLD;
                  hold_cnt_q <= '0;
                  timer_q    <= '0;
                  stable_q   <= '0;
                  resetb_q   <= 1'b0;
                  bypass_q   <= 1'b0;
                  ready_q    <= 1'b0;
                  fault_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pll_resetb_o  = resetb_q;
   assign pll_bypass_o  = bypass_q;
   assign pll_ready_o   = ready_q;
   assign pll_fault_o   = fault_q;
   assign retry_count_o = retry_q;
   assign loss_count_o  = loss_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_tx_pll_sequencer.sv
// Directed scoreboard bench for tx_pll_sequencer: every output change is popped
// against a queued expectation carrying the absolute cycle it must appear on.
module tb_tx_pll_sequencer;

   localparam logic [2:0] S_HOLD   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_FILTER = 3'd2;
   localparam logic [2:0] S_LOCKED = 3'd3;
   localparam logic [2:0] S_FAULT  = 3'd4;
   localparam logic [2:0] S_BYPASS = 3'd5;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       pll_lock_i = 1'b0;
   logic       force_bypass_i = 1'b0;
   logic       restart_i = 1'b0;
   logic       pll_resetb_o, pll_bypass_o, pll_ready_o, pll_fault_o;
   logic [3:0] retry_count_o;
   logic [7:0] loss_count_o;
   logic [2:0] state_o;

   typedef struct {
      logic [18:0] vec;
      int          at;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   tx_pll_sequencer #(
      .RESET_CYCLES(4), .LOCK_TIMEOUT(100), .LOCK_STABLE(8), .MAX_RETRIES(2)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .pll_lock_i(pll_lock_i),
      .force_bypass_i(force_bypass_i), .restart_i(restart_i),
      .pll_resetb_o(pll_resetb_o), .pll_bypass_o(pll_bypass_o),
      .pll_ready_o(pll_ready_o), .pll_fault_o(pll_fault_o),
      .retry_count_o(retry_count_o), .loss_count_o(loss_count_o),
      .state_o(state_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input logic [2:0] st, input logic rb, input logic bp,
                       input logic rd, input logic ft, input logic [3:0] rc,
                       input logic [7:0] lc, input int at);
      exp_t e;
      e.vec = {st, rb, bp, rd, ft, rc, lc};
      e.at  = at;
      sb_q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pops one expectation per observed output change
   initial begin
      logic [18:0] prev_v;
      logic [18:0] cur_v;
      exp_t        e;
      prev_v = '1;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur_v = {state_o, pll_resetb_o, pll_bypass_o, pll_ready_o, pll_fault_o,
                     retry_count_o, loss_count_o};
            checks++;
            if ((pll_ready_o && pll_bypass_o) || (pll_ready_o && !pll_resetb_o)) begin
               errors++;
               $display("FAIL invariant cyc=%0d ready=%0b bypass=%0b resetb=%0b required ready=0 or (resetb=1,bypass=0)",
                        cyc, pll_ready_o, pll_bypass_o, pll_resetb_o);
            end
            if (cur_v != prev_v) begin
               checks++;
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_change cyc=%0d got=%h required no change", cyc, cur_v);
               end else begin
                  e = sb_q.pop_front();
                  if (cur_v != e.vec) begin
                     errors++;
                     $display("FAIL outputs cyc=%0d got st=%0d rb=%0b bp=%0b rd=%0b ft=%0b rc=%0d lc=%0d required vec=%h",
                              cyc, state_o, pll_resetb_o, pll_bypass_o, pll_ready_o,
                              pll_fault_o, retry_count_o, loss_count_o, e.vec);
                  end
                  if (e.at >= 0) begin
                     checks++;
                     if (cyc != e.at) begin
                        errors++;
                        $display("FAIL timing got cyc=%0d required cyc=%0d (vec=%h)", cyc, e.at, e.vec);
                     end
                  end
               end
               prev_v = cur_v;
            end
         end
      end
   end

   initial begin
      repeat (5000) @(posedge clk);
      errors++;
      $display("FAIL watchdog cyc=%0d pending=%0d required completion", cyc, sb_q.size());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int r, d, f, g, h, p, q;
      repeat (3) @(posedge clk);
      #1;
      push(S_HOLD, 0, 0, 0, 0, 4'd0, 8'd0, -1);
      mon_en = 1'b1;

      // Release reset, lock 20 cycles after RESETB rises
      r = cyc;
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd0, r + 4);
      push(S_FILTER, 1, 0, 0, 0, 4'd0, 8'd0, r + 27);
      push(S_LOCKED, 1, 0, 1, 0, 4'd0, 8'd0, r + 34);
      reset_i = 1'b0;
      wait_until(r + 24);
      pll_lock_i = 1'b1;
      wait_until(r + 40);

      // One-cycle loss of lock while LOCKED, then relock
      d = cyc;
      push(S_HOLD,   0, 0, 0, 0, 4'd0, 8'd1, d + 3);
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd1, d + 7);
      push(S_FILTER, 1, 0, 0, 0, 4'd0, 8'd1, d + 8);
      push(S_LOCKED, 1, 0, 1, 0, 4'd0, 8'd1, d + 15);
      pll_lock_i = 1'b0;
      wait_until(d + 1);
      pll_lock_i = 1'b1;
      wait_until(d + 20);

      // FORCE_BYPASS with RESTART in LOCKED; RESTART in BYPASS is ignored
      f = cyc;
      push(S_BYPASS, 0, 1, 0, 0, 4'd0, 8'd1, f + 1);
      force_bypass_i = 1'b1;
      restart_i = 1'b1;
      wait_until(f + 1);
      restart_i = 1'b0;
      wait_until(f + 3);
      restart_i = 1'b1;
      wait_until(f + 4);
      restart_i = 1'b0;
      wait_until(f + 6);
      g = cyc;
      push(S_HOLD,   0, 0, 0, 0, 4'd0, 8'd1, g + 1);
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd1, g + 5);
      push(S_FILTER, 1, 0, 0, 0, 4'd0, 8'd1, g + 6);
      push(S_LOCKED, 1, 0, 1, 0, 4'd0, 8'd1, g + 13);
      force_bypass_i = 1'b0;
      wait_until(g + 20);

      // Lock lost, 5-cycle glitch, two timeouts into FAULT
      h = cyc;
      push(S_HOLD,   0, 0, 0, 0, 4'd0, 8'd2, h + 3);
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd2, h + 7);
      push(S_FILTER, 1, 0, 0, 0, 4'd0, 8'd2, h + 13);
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd2, h + 18);
      push(S_HOLD,   0, 0, 0, 0, 4'd1, 8'd2, h + 107);
      push(S_WAIT,   1, 0, 0, 0, 4'd1, 8'd2, h + 111);
      push(S_FAULT,  0, 1, 0, 1, 4'd2, 8'd2, h + 211);
      pll_lock_i = 1'b0;
      wait_until(h + 10);
      pll_lock_i = 1'b1;
      wait_until(h + 15);
      pll_lock_i = 1'b0;
      wait_until(h + 215);

      // RESTART out of FAULT, normal lock follows
      p = cyc;
      push(S_HOLD,   0, 0, 0, 0, 4'd0, 8'd2, p + 1);
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd2, p + 5);
      push(S_FILTER, 1, 0, 0, 0, 4'd0, 8'd2, p + 6);
      push(S_LOCKED, 1, 0, 1, 0, 4'd0, 8'd2, p + 13);
      restart_i = 1'b1;
      pll_lock_i = 1'b1;
      wait_until(p + 1);
      restart_i = 1'b0;
      wait_until(p + 20);

      // RESET in FILTER at stable count 5, then relock from scratch
      q = cyc;
      push(S_HOLD,   0, 0, 0, 0, 4'd0, 8'd3, q + 3);
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd3, q + 7);
      push(S_FILTER, 1, 0, 0, 0, 4'd0, 8'd3, q + 10);
      push(S_HOLD,   0, 0, 0, 0, 4'd0, 8'd0, q + 15);
      push(S_WAIT,   1, 0, 0, 0, 4'd0, 8'd0, q + 20);
      push(S_FILTER, 1, 0, 0, 0, 4'd0, 8'd0, q + 21);
      push(S_LOCKED, 1, 0, 1, 0, 4'd0, 8'd0, q + 28);
      pll_lock_i = 1'b0;
      wait_until(q + 7);
      pll_lock_i = 1'b1;
      wait_until(q + 14);
      reset_i = 1'b1;
      wait_until(q + 16);
      reset_i = 1'b0;
      wait_until(q + 40);

      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
